// File: rtl/dft64_unloader_if.sv
// Bin stream carrying the 64 complex DFT results, one bin per valid/ready transfer.
interface dft64_unloader_if #(
    parameter int WIDTH = 16
);
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_real;
    logic [WIDTH-1:0] out_imag;
    logic [5:0]       out_index;
    logic             out_last;

    modport master (
        output out_valid, out_real, out_imag, out_index, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_real, out_imag, out_index, out_last,
        output out_ready
    );
endinterface

// File: rtl/dft64_unloader.sv
// Shadows a completed dft64 frame and streams its 64 bins over a valid/ready bus.
// Optional DFT64_UNLOAD_MAG_EN: out_imag carries max+min/2 magnitude instead of imag.
module dft64_unloader #(
    parameter int WIDTH     = 16,
    parameter int COL_MAJOR = 0
) (
    input  logic                clk,
    input  logic                sreset,
    input  logic                done_in,
    input  logic [WIDTH-1:0]    realfft_in [0:7][0:7],
    input  logic [WIDTH-1:0]    imagfft_in [0:7][0:7],
    dft64_unloader_if.master    out_if,
    output logic                busy,
    output logic                overrun,
    output logic [7:0]          frame_count
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t           state_r, state_next_s;
    logic [5:0]       idx_r, idx_next_s;
    logic             capture_s, fire_s, final_s, overrun_set_s;
    logic [2:0]       rd_row_s, rd_col_s;
    logic [WIDTH-1:0] rd_real_s, rd_imag_s, out_imag_next_s;
    logic [WIDTH-1:0] shadow_real_r [0:7][0:7];
    logic [WIDTH-1:0] shadow_imag_r [0:7][0:7];

`ifdef DFT64_UNLOAD_MAG_EN
    // Two's-complement absolute value; the most negative code saturates to max positive.
    function automatic logic [WIDTH-1:0] sat_abs_f(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] res;
        if (v == {1'b1, {(WIDTH-1){1'b0}}}) begin
            res = {1'b0, {(WIDTH-1){1'b1}}};
        end else if (v[WIDTH-1]) begin
            res = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            res = v;
        end
        return res;
    endfunction

    function automatic logic [WIDTH-1:0] mag_f(input logic [WIDTH-1:0] re,
                                               input logic [WIDTH-1:0] im);
        logic [WIDTH-1:0] a, b, mx, mn, max_pos;
        logic [WIDTH:0]   sum;
        max_pos = {1'b0, {(WIDTH-1){1'b1}}};
        a = sat_abs_f(re);
        b = sat_abs_f(im);
        if (a >= b) begin
            mx = a;
            mn = b;
        end else begin
            mx = b;
            mn = a;
        end
        sum = {1'b0, mx} + {2'b00, mn[WIDTH-1:1]};
        if (sum > {1'b0, max_pos}) begin
            return max_pos;
        end else begin
            return sum[WIDTH-1:0];
        end
    endfunction
`endif

    assign fire_s = (state_r == STREAM) && out_if.out_ready;

    // Next-state, index and capture/overrun decisions.
    always_comb begin
        state_next_s  = state_r;
        idx_next_s    = idx_r;
        capture_s     = 1'b0;
        overrun_set_s = 1'b0;
        final_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (done_in) begin
                    capture_s    = 1'b1;
                    idx_next_s   = 6'd0;
                    state_next_s = STREAM;
                end else begin
                    state_next_s = IDLE;
                end
            end
            STREAM: begin
                if (fire_s && (idx_r == 6'd63)) begin
                    final_s = 1'b1;
                    // A frame arriving exactly as the last bin leaves is accepted back-to-back.
                    if (done_in) begin
                        capture_s    = 1'b1;
                        idx_next_s   = 6'd0;
                        state_next_s = STREAM;
                    end else begin
                        state_next_s = IDLE;
                    end
                end else if (fire_s) begin
                    idx_next_s    = idx_r + 6'd1;
                    overrun_set_s = done_in;
                end else begin
                    overrun_set_s = done_in;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Map the upcoming bin index to a shadow row/column.
    always_comb begin
        if (COL_MAJOR != 32'sd0) begin
            rd_row_s = idx_next_s[2:0];
            rd_col_s = idx_next_s[5:3];
        end else begin
            rd_row_s = idx_next_s[5:3];
            rd_col_s = idx_next_s[2:0];
        end
    end

    // Bin 0 of a frame being captured is taken straight from the input arrays.
    always_comb begin
        if (capture_s) begin
            rd_real_s = realfft_in[0][0];
            rd_imag_s = imagfft_in[0][0];
        end else begin
            rd_real_s = shadow_real_r[rd_row_s][rd_col_s];
            rd_imag_s = shadow_imag_r[rd_row_s][rd_col_s];
        end
`ifdef DFT64_UNLOAD_MAG_EN
        out_imag_next_s = mag_f(rd_real_s, rd_imag_s);
`else
        out_imag_next_s = rd_imag_s;
`endif
    end

    // State, index and status registers.
    always_ff @(posedge clk) begin
        if (sreset) begin
            state_r     <= IDLE;
            idx_r       <= 6'd0;
            overrun     <= 1'b0;
            frame_count <= 8'd0;
        end else begin
            state_r <= state_next_s;
            idx_r   <= idx_next_s;
            if (overrun_set_s) begin
                overrun <= 1'b1;
            end
            if (final_s) begin
                frame_count <= frame_count + 8'd1;
            end
        end
    end

    // Shadow copy of the result arrays.
    always_ff @(posedge clk) begin
        if (sreset) begin
            for (int r = 0; r < 8; r++) begin
                for (int c = 0; c < 8; c++) begin
                    shadow_real_r[r][c] <= '0;
                    shadow_imag_r[r][c] <= '0;
                end
            end
        end else if (capture_s) begin
            shadow_real_r <= realfft_in;
            shadow_imag_r <= imagfft_in;
        end
    end

    // Registered stream outputs; reloading from an unchanged index holds them under backpressure.
    always_ff @(posedge clk) begin
        if (sreset) begin
            out_if.out_valid <= 1'b0;
            out_if.out_real  <= '0;
            out_if.out_imag  <= '0;
            out_if.out_index <= 6'd0;
            out_if.out_last  <= 1'b0;
            busy             <= 1'b0;
        end else begin
            out_if.out_valid <= (state_next_s == STREAM);
            out_if.out_real  <= rd_real_s;
            out_if.out_imag  <= out_imag_next_s;
            out_if.out_index <= idx_next_s;
            out_if.out_last  <= (state_next_s == STREAM) && (idx_next_s == 6'd63);
            busy             <= (state_next_s == STREAM);
        end
    end

endmodule

// File: tb/tb_dft64_unloader.sv
// Randomized bench for dft64_unloader: row-major and column-major instances against a frame/beat model.
module tb_dft64_unloader;
    localparam int W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         sreset = 1'b1;
    logic         done_in = 1'b0;
    logic [W-1:0] re_in [0:7][0:7];
    logic [W-1:0] im_in [0:7][0:7];

    dft64_unloader_if #(.WIDTH(W)) if_row ();
    dft64_unloader_if #(.WIDTH(W)) if_col ();

    logic       busy_o [0:1];
    logic       ovr_o  [0:1];
    logic [7:0] fc_o   [0:1];

    dft64_unloader #(.WIDTH(W), .COL_MAJOR(0)) u_row (
        .clk(clk), .sreset(sreset), .done_in(done_in),
        .realfft_in(re_in), .imagfft_in(im_in), .out_if(if_row.master),
        .busy(busy_o[0]), .overrun(ovr_o[0]), .frame_count(fc_o[0])
    );

    dft64_unloader #(.WIDTH(W), .COL_MAJOR(1)) u_col (
        .clk(clk), .sreset(sreset), .done_in(done_in),
        .realfft_in(re_in), .imagfft_in(im_in), .out_if(if_col.master),
        .busy(busy_o[1]), .overrun(ovr_o[1]), .frame_count(fc_o[1])
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: the frame being streamed and how many of its bins have left.
    bit           m_active = 1'b0;
    int           m_beat = 0;
    bit           m_overrun = 1'b0;
    logic [7:0]   m_frames = 8'd0;
    logic [W-1:0] m_re [0:7][0:7];
    logic [W-1:0] m_im [0:7][0:7];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] exp_imag(input logic [W-1:0] re, input logic [W-1:0] im);
`ifdef DFT64_UNLOAD_MAG_EN
        int a, b, mx, mn, s;
        a = $signed(re);
        b = $signed(im);
        a = (a < 0) ? -a : a;
        b = (b < 0) ? -b : b;
        if (a > 32767) a = 32767;
        if (b > 32767) b = 32767;
        mx = (a > b) ? a : b;
        mn = (a > b) ? b : a;
        s = mx + mn / 2;
        if (s > 32767) s = 32767;
        return s[W-1:0];
`else
        return (re === re) ? im : im;
`endif
    endfunction

    task automatic check_all();
        logic       v [0:1];
        logic [W-1:0] rr [0:1];
        logic [W-1:0] ii [0:1];
        logic [5:0] ix [0:1];
        logic       ls [0:1];
        int r, c;
        v[0] = if_row.out_valid;  v[1] = if_col.out_valid;
        rr[0] = if_row.out_real;  rr[1] = if_col.out_real;
        ii[0] = if_row.out_imag;  ii[1] = if_col.out_imag;
        ix[0] = if_row.out_index; ix[1] = if_col.out_index;
        ls[0] = if_row.out_last;  ls[1] = if_col.out_last;
        for (int m = 0; m < 2; m++) begin
            check_eq($sformatf("valid[%0d]", m), 32'(v[m]), 32'(m_active));
            check_eq($sformatf("busy[%0d]", m), 32'(busy_o[m]), 32'(m_active));
            check_eq($sformatf("overrun[%0d]", m), 32'(ovr_o[m]), 32'(m_overrun));
            check_eq($sformatf("frame_count[%0d]", m), 32'(fc_o[m]), 32'(m_frames));
            if (m_active) begin
                r = (m == 0) ? m_beat / 8 : m_beat % 8;
                c = (m == 0) ? m_beat % 8 : m_beat / 8;
                check_eq($sformatf("index[%0d]", m), 32'(ix[m]), 32'(m_beat));
                check_eq($sformatf("real[%0d]", m), 32'(rr[m]), 32'(m_re[r][c]));
                check_eq($sformatf("imag[%0d]", m), 32'(ii[m]), 32'(exp_imag(m_re[r][c], m_im[r][c])));
                check_eq($sformatf("last[%0d]", m), 32'(ls[m]), 32'(m_beat == 63));
            end else if (sreset == 1'b1) begin
                check_eq($sformatf("rst_last[%0d]", m), 32'(ls[m]), 32'd0);
            end else begin
                check_eq($sformatf("idle_last[%0d]", m), 32'(ls[m]), 32'd0);
            end
        end
    endtask

    // Apply one clock of inputs, advance the model, then check at the falling edge.
    task automatic step(input bit d, input bit rdy, input bit rst);
        bit was, fire, fin;
        sreset  = rst;
        done_in = d;
        if_row.out_ready = rdy;
        if_col.out_ready = rdy;
        if (rst) begin
            m_active = 1'b0; m_beat = 0; m_overrun = 1'b0; m_frames = 8'd0;
        end else begin
            was  = m_active;
            fire = m_active && rdy;
            fin  = fire && (m_beat == 63);
            if (fin) begin
                m_active = 1'b0;
                m_frames = m_frames + 8'd1;
            end else if (fire) begin
                m_beat++;
            end
            if (d) begin
                if (!was || fin) begin
                    m_re = re_in; m_im = im_in; m_beat = 0; m_active = 1'b1;
                end else begin
                    m_overrun = 1'b1;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic fill_ramp();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                re_in[r][c] = W'(16 * r + c);
                im_in[r][c] = W'(-(16 * r + c));
            end
    endtask

    task automatic fill_random();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                case ($urandom_range(0, 7))
                    0: begin re_in[r][c] = 16'h8000; im_in[r][c] = W'($urandom); end
                    1: begin re_in[r][c] = 16'hFFFD; im_in[r][c] = 16'h0004; end
                    2: begin re_in[r][c] = 16'h7FFF; im_in[r][c] = 16'h8000; end
                    default: begin re_in[r][c] = W'($urandom); im_in[r][c] = W'($urandom); end
                endcase
            end
    endtask

    initial begin
        fill_ramp();
        if_row.out_ready = 1'b0;
        if_col.out_ready = 1'b0;
        @(negedge clk);
        // Reset, including a done pulse that must be ignored while held.
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, 1'($urandom), 1'b0);

        // Ramp frame, full throughput; inputs scrambled after capture.
        fill_ramp();
        step(1'b1, 1'b1, 1'b0);
        fill_random();
        for (int i = 0; i < 70; i++) step(1'b0, 1'b1, 1'b0);

        // Same frame with ready pattern 1,0,0,1.
        fill_ramp();
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 400 && m_active; i++) step(1'b0, (i % 4 == 0) || (i % 4 == 3), 1'b0);

        // Overrun: second done ten cycles into the stream.
        fill_random();
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b0);
        fill_random();
        step(1'b1, 1'b1, 1'b0);
        fill_random();
        for (int i = 0; i < 80; i++) step(1'b0, 1'b1, 1'b0);

        // Reset mid-stream, then back-to-back frames.
        fill_random();
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0);
        fill_random();
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 500 && !(m_active && m_beat == 63); i++) step(1'b0, 1'($urandom), 1'b0);
        fill_random();
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 80; i++) step(1'b0, 1'b1, 1'b0);

        // Enough back-to-back frames to wrap frame_count.
        step(1'b0, 1'b1, 1'b1);
        fill_random();
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 258 * 64; i++) begin
            if (m_active && m_beat == 63) begin
                fill_random();
                step(1'b1, 1'b1, 1'b0);
            end else begin
                step(1'b0, 1'b1, 1'b0);
            end
        end
        for (int i = 0; i < 70; i++) step(1'b0, 1'b1, 1'b0);

        // Free-running random traffic.
        for (int i = 0; i < 4000; i++) begin
            bit d;
            d = ($urandom_range(0, 39) == 0);
            if (d) fill_random();
            step(d, ($urandom_range(0, 3) != 0), ($urandom_range(0, 499) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
